// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first frames with repeat and idle gap
module seq_pattern_tx #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   shift_reg, shift_n;
  logic [WIDTH-1:0]   hold_reg, hold_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [CNT_W-1:0]   rep_cnt, rep_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               ready_n, out_n, out_valid_n, done_n;

  // State, datapath and output registers; outputs are computed from the next
  // state so that they are true flops yet line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      ready     <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      hold_reg  <= hold_n;
      bit_cnt   <= bit_n;
      rep_cnt   <= rep_n;
      gap_cnt   <= gap_n;
      ready     <= ready_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      done      <= done_n;
    end
  end

  // Next-state and datapath update: frame sequencing, repeat and gap control.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    hold_n  = hold_reg;
    bit_n   = bit_cnt;
    rep_n   = rep_cnt;
    gap_n   = gap_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          hold_n  = pattern;
          shift_n = pattern;
          rep_n   = (reps == '0) ? CNT_W'(1) : reps;
          bit_n   = BIT_W'(WIDTH - 1);
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        shift_n = {shift_reg[WIDTH-2:0], 1'b0};
        bit_n   = bit_cnt - BIT_W'(1);
        if (bit_cnt == '0) begin
          rep_n = rep_cnt - CNT_W'(1);
          if (rep_cnt > CNT_W'(1)) begin
            if (GAP_CYCLES > 0) begin
              gap_n   = GAP_W'(GAP_CYCLES - 1);
              state_n = GAP;
            end else begin
              // Back-to-back frames: reload immediately so there is no bubble.
              shift_n = hold_reg;
              bit_n   = BIT_W'(WIDTH - 1);
            end
          end else begin
            state_n = DONE;
          end
        end
      end

      GAP: begin
        gap_n = gap_cnt - GAP_W'(1);
        if (gap_cnt == '0) begin
          shift_n = hold_reg;
          bit_n   = BIT_W'(WIDTH - 1);
          state_n = SHIFT;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore output decode of the upcoming state, registered above.
  always_comb begin
    ready_n     = (state_n == IDLE);
    out_valid_n = (state_n == SHIFT);
    out_n       = (state_n == SHIFT) ? shift_n[WIDTH-1] : 1'b0;
    done_n      = (state_n == DONE);
  end

endmodule
